rom_async_reader: RTL and testbench

//  Synchronous read controller for a 27256-class async EPROM (CEn/OEn, ~150 ns tACC).

---
 rtl/rom_if_pkg.sv | 13 +
 rtl/rom_wait_timer.sv | 36 +++
 rtl/rom_async_reader.sv | 158 +++++++++++++++
 tb/tb_rom_async_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_if_pkg.sv
// rtl/rom_if_pkg.sv - shared EPROM interface constants and wait-cycle helper
package rom_if_pkg;

  localparam int EPROM_TACC_NS = 150;
  localparam int ROM_DATA_W    = 8;
  localparam int ROM_ADDR_W    = 15;

  // Access wait in clocks for a given clock period: ceil(tACC/period) + 1
  function automatic int wait_cycles(input int clk_period_ns);
    return (EPROM_TACC_NS + clk_period_ns - 1) / clk_period_ns + 1;
  endfunction

endpackage

// File: rtl/rom_wait_timer.sv
// rtl/rom_wait_timer.sv - loadable down-counter with zero flag, shared by access and recovery
module rom_wait_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load wins over decrement; the counter parks at zero rather than wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rom_async_reader.sv
// rtl/rom_async_reader.sv - single-outstanding read controller for a CEn/OEn async EPROM
module rom_async_reader
  import rom_if_pkg::*;
#(
  parameter int DATA_WIDTH     = ROM_DATA_W,
  parameter int ADDR_WIDTH     = ROM_ADDR_W,
  parameter int WAIT_CYCLES    = 8,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  REQ_VALID,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  output logic                  REQ_READY,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DOUT_VALID,
  output logic                  BUSY,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  output logic                  ROM_CEn,
  output logic                  ROM_OEn,
  input  logic [DATA_WIDTH-1:0] ROM_DATA
);

  localparam int CNT_MAX = (WAIT_CYCLES > RECOVER_CYCLES) ? WAIT_CYCLES : RECOVER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD    = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LOAD =
      (RECOVER_CYCLES > 0) ? CNT_W'(RECOVER_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RECOVER = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  rom_cen_q, rom_cen_d;
  logic                  rom_oen_q, rom_oen_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  req_ready_q, req_ready_d;
  logic                  busy_q, busy_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_dec;
  logic             tmr_zero;

  rom_wait_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk_i      (CLK),
    .rst_ni     (RSTn),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    rom_cen_d    = rom_cen_q;
    rom_oen_d    = rom_oen_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    req_ready_d  = req_ready_q;
    busy_d       = busy_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Ready rises on the first edge after reset release and stays up while idle
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (REQ_VALID && req_ready_q) begin
          rom_addr_d   = REQ_ADDR;
          rom_cen_d    = 1'b0;
          rom_oen_d    = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = WAIT_LOAD;
          req_ready_d  = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          dout_d       = ROM_DATA;
          dout_valid_d = 1'b1;
          rom_cen_d    = 1'b1;
          rom_oen_d    = 1'b1;
          if (RECOVER_CYCLES > 0) begin
            tmr_load     = 1'b1;
            tmr_load_val = RECOVER_LOAD;
            state_d      = S_RECOVER;
          end else begin
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
          end
        end
      end

      S_RECOVER: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Async reset lifts the strobes immediately, so an aborted access never yields data
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= '0;
      rom_cen_q    <= 1'b1;
      rom_oen_q    <= 1'b1;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      rom_cen_q    <= rom_cen_d;
      rom_oen_q    <= rom_oen_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign REQ_READY  = req_ready_q;
  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign BUSY       = busy_q;
  assign ROM_ADDR   = rom_addr_q;
  assign ROM_CEn    = rom_cen_q;
  assign ROM_OEn    = rom_oen_q;

endmodule

// File: tb/tb_rom_async_reader.sv
// tb/tb_rom_async_reader.sv - directed bench: W8/R1 main, W7/R1 short-wait, W1/R0 sweep
`timescale 1ns/1ps
module tb_rom_async_reader;

  logic        clk;
  logic        rstn;
  logic        req_valid  [3];
  logic [14:0] req_addr   [3];
  logic        req_ready  [3];
  logic [7:0]  dout       [3];
  logic        dout_valid [3];
  logic        busy       [3];
  logic [14:0] rom_addr   [3];
  logic        rom_cen    [3];
  logic        rom_oen    [3];

  logic        model_ok   [3];
  logic        ok_at_cap  [3];
  logic [14:0] prev_addr  [3];
  logic        prev_en    [3];
  time         t_start    [3];
  int          run        [3];
  int          last_run   [3];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int WC = (g == 0) ? 8 : (g == 1) ? 7 : 1;
    localparam int RC = (g == 2) ? 0 : 1;
    rom_async_reader #(
      .DATA_WIDTH     (8),
      .ADDR_WIDTH     (15),
      .WAIT_CYCLES    (WC),
      .RECOVER_CYCLES (RC)
    ) u_dut (
      .CLK        (clk),
      .RSTn       (rstn),
      .REQ_VALID  (req_valid[g]),
      .REQ_ADDR   (req_addr[g]),
      .REQ_READY  (req_ready[g]),
      .DOUT       (dout[g]),
      .DOUT_VALID (dout_valid[g]),
      .BUSY       (busy[g]),
      .ROM_ADDR   (rom_addr[g]),
      .ROM_CEn    (rom_cen[g]),
      .ROM_OEn    (rom_oen[g]),
      .ROM_DATA   (model_ok[g] ? (rom_addr[g][7:0] ^ 8'h5A) : 8'h00)
    );
  end

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // EPROM model: data only after tACC of stable enabled address; 0 stands in for high-Z.
  // The sweep instance gets a zero-latency part so its data can be checked.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      longint tacc;
      tacc = (i == 2) ? 0 : 150;
      if (rom_addr[i] !== prev_addr[i] || (!rom_cen[i] && !rom_oen[i]) !== prev_en[i]) begin
        t_start[i] = $time - 10;
      end
      prev_addr[i] = rom_addr[i];
      prev_en[i]   = !rom_cen[i] && !rom_oen[i];
      model_ok[i]  = prev_en[i] && (longint'($time) + 10 - longint'(t_start[i]) >= tacc);
      if (!rom_cen[i]) begin
        run[i] = run[i] + 1;
      end else begin
        if (run[i] != 0) last_run[i] = run[i];
        run[i] = 0;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) ok_at_cap[i] <= model_ok[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_accept(input int g, input logic [14:0] a);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (!rom_cen[g] && rom_addr[g] == a && !req_ready[g]) found = 1'b1;
    end
    check("accept_seen", found, 1'b1);
  endtask

  task automatic wait_dv(input int g, output int lat);
    logic found;
    found = 1'b0;
    lat   = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      lat++;
      if (dout_valid[g]) found = 1'b1;
    end
    check("dout_valid_seen", found, 1'b1);
  endtask

  task automatic burst(input int g, input int base, input int n, input int space, input int wc);
    int idx, pulses, last, cyc;
    logic [14:0] a;
    idx = 0; pulses = 0; last = 0; cyc = 0;
    req_addr[g]  = 15'(base);
    req_valid[g] = 1'b1;
    while (pulses < n && cyc < 200) begin
      step();
      cyc++;
      if (idx < n && !rom_cen[g] && rom_addr[g] == 15'(base + idx)) begin
        idx++;
        if (idx < n) req_addr[g] = 15'(base + idx);
        else req_valid[g] = 1'b0;
      end
      if (dout_valid[g]) begin
        a = 15'(base + pulses);
        check("burst_dout", dout[g], a[7:0] ^ 8'h5A);
        check("burst_strobe_len", last_run[g], wc);
        if (pulses > 0) check("burst_spacing", cyc - last, space);
        last = cyc;
        pulses++;
      end
    end
    req_valid[g] = 1'b0;
    check("burst_count", pulses, n);
  endtask

  initial begin
    int lat, dv_cnt;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i]  = '0;
      run[i]       = 0;
      last_run[i]  = 0;
    end

    // Reset state
    step(); step();
    check("rst_cen", rom_cen[0], 1'b1);
    check("rst_oen", rom_oen[0], 1'b1);
    check("rst_addr", rom_addr[0], 15'h0);
    check("rst_dout", dout[0], 8'h00);
    check("rst_dv", dout_valid[0], 1'b0);
    check("rst_ready", req_ready[0], 1'b0);
    check("rst_busy", busy[0], 1'b0);
    rstn = 1'b1;
    step();
    check("ready_after_release", req_ready[0], 1'b1);

    // 1: single read of 0x0012
    req_addr[0]  = 15'h0012;
    req_valid[0] = 1'b1;
    step();
    check("t1_cen_low", rom_cen[0], 1'b0);
    check("t1_oen_low", rom_oen[0], 1'b0);
    check("t1_rom_addr", rom_addr[0], 15'h0012);
    check("t1_ready_low", req_ready[0], 1'b0);
    check("t1_busy", busy[0], 1'b1);
    req_valid[0] = 1'b0;
    req_addr[0]  = 15'h0555;
    wait_dv(0, lat);
    check("t1_latency", lat, 8);
    check("t1_dout", dout[0], 8'h48);
    check("t1_strobe_len", last_run[0], 8);
    check("t1_data_settled", ok_at_cap[0], 1'b1);
    check("t1_cen_high", rom_cen[0], 1'b1);
    check("t1_addr_kept", rom_addr[0], 15'h0012);
    step();
    check("t1_dv_pulse", dout_valid[0], 1'b0);
    check("t1_ready_back", req_ready[0], 1'b1);
    check("t1_busy_clear", busy[0], 1'b0);
    check("t1_dout_held", dout[0], 8'h48);

    // 2: back-to-back 0x0000..0x0003
    burst(0, 0, 4, 10, 8);

    // 3: address changed after accept
    req_addr[0]  = 15'h0001;
    req_valid[0] = 1'b1;
    wait_accept(0, 15'h0001);
    req_addr[0]  = 15'h7FFF;
    wait_dv(0, lat);
    check("t3_latency", lat, 8);
    check("t3_addr_held", rom_addr[0], 15'h0001);
    check("t3_dout", dout[0], 8'h5B);
    wait_accept(0, 15'h7FFF);
    req_valid[0] = 1'b0;
    wait_dv(0, lat);
    check("t3_dout_next", dout[0], 8'hA5);

    // 4: reset in the middle of an access
    req_addr[0]  = 15'h0034;
    req_valid[0] = 1'b1;
    wait_accept(0, 15'h0034);
    req_valid[0] = 1'b0;
    step(); step(); step();
    rstn = 1'b0;
    #1;
    check("t4_cen_async", rom_cen[0], 1'b1);
    check("t4_oen_async", rom_oen[0], 1'b1);
    check("t4_dout_cleared", dout[0], 8'h00);
    check("t4_ready_low", req_ready[0], 1'b0);
    check("t4_busy_low", busy[0], 1'b0);
    step(); step();
    rstn = 1'b1;
    step();
    check("t4_ready_one_edge", req_ready[0], 1'b1);
    dv_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (dout_valid[0]) dv_cnt++;
    end
    check("t4_no_dv", dv_cnt, 0);
    check("t4_dout_zero", dout[0], 8'h00);

    // 5a: WAIT_CYCLES=7 captures before tACC
    req_addr[1]  = 15'h0012;
    req_valid[1] = 1'b1;
    wait_accept(1, 15'h0012);
    req_valid[1] = 1'b0;
    wait_dv(1, lat);
    check("t5_w7_latency", lat, 7);
    check("t5_w7_strobe_len", last_run[1], 7);
    check("t5_w7_premature_capture", ok_at_cap[1], 1'b0);

    // 5b: WAIT_CYCLES=1, RECOVER_CYCLES=0 sweep
    burst(2, 16'h0010, 4, 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
